// File: rtl/interval_chain_adder.sv
// interval_chain_adder
//   Pipelined chain of STAGES signed add/clamp stages. Each stage adds its
//   own addend (captured with the item at input transfer) to the running value
//   and clamps the sum into [LO, HI]. A per-stage clamp bitmap travels with the
//   item. Valid/ready flow control lets bubbles collapse; the output registers
//   hold while stalled.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_data [W]          signed start value
//   in_addend [STAGES*W] flattened addends, slice k (k*W +: W) feeds stage k
//   out_valid/out_ready  output handshake
//   out_data [W]         signed final result
//   out_clamped          OR of out_clamp_stage
//   out_clamp_stage      bit k set when stage k clamped this item
//
// Optional feature (macro INTERVAL_CHAIN_STATS_EN)
//   stat_items  [32]     saturating count of output handshakes
//   stat_clamps [32]     saturating count of handshakes with out_clamped = 1

module interval_chain_adder #(
   parameter int W      = 8,
   parameter int STAGES = 3,
   parameter int LO     = -100,
   parameter int HI     = 100
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   input  logic [STAGES*W-1:0]   in_addend,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W-1:0]          out_data,
   output logic                  out_clamped,
   output logic [STAGES-1:0]     out_clamp_stage
`ifdef INTERVAL_CHAIN_STATS_EN
   ,
   output logic [31:0]           stat_items,
   output logic [31:0]           stat_clamps
`endif
);

   localparam logic signed [W:0] LO_X = (W+1)'(LO);
   localparam logic signed [W:0] HI_X = (W+1)'(HI);

   // Returns {clamp_hit, result}; the sum is formed at W+1 bits so it cannot wrap.
   function automatic logic [W:0] add_clamp(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W:0] s;
      s = $signed({a[W-1], a}) + $signed({b[W-1], b});
      if (s < LO_X)
         add_clamp = {1'b1, LO_X[W-1:0]};
      else if (s > HI_X)
         add_clamp = {1'b1, HI_X[W-1:0]};
      else
         add_clamp = {1'b0, s[W-1:0]};
   endfunction

   logic [STAGES-1:0]   vld;
   logic [W-1:0]        dat   [STAGES];
   logic [STAGES-1:0]   clp   [STAGES];
   logic [STAGES*W-1:0] addq  [STAGES];
   logic [STAGES-1:0]   adv;
   logic [W-1:0]        res   [STAGES];
   logic [STAGES-1:0]   hit;

   // Advance chain: a stage moves when empty or when its successor moves.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = ~vld[STAGES-1] | out_ready;
      for (int unsigned j = 1; j < STAGES; j++)
         adv[STAGES-1-j] = ~vld[STAGES-1-j] | adv[STAGES-j];
   end

   // Stage 0 works on the live input; later stages use the addends captured with the item.
   always_comb begin
      hit = '0;
      {hit[0], res[0]} = add_clamp(in_data, in_addend[W-1:0]);
      for (int unsigned k = 1; k < STAGES; k++)
         {hit[k], res[k]} = add_clamp(dat[k-1], addq[k-1][k*W +: W]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            dat[k]  <= '0;
            clp[k]  <= '0;
            addq[k] <= '0;
         end
      end else begin
         if (adv[0]) begin
            vld[0] <= in_valid;
            if (in_valid) begin
               dat[0]  <= res[0];
               clp[0]  <= STAGES'(hit[0]);
               addq[0] <= in_addend;
            end
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) begin
                  dat[k]  <= res[k];
                  clp[k]  <= clp[k-1] | (STAGES'(hit[k]) << k);
                  addq[k] <= addq[k-1];
               end
            end
         end
      end
   end

   assign in_ready        = adv[0];
   assign out_valid       = vld[STAGES-1];
   assign out_data        = dat[STAGES-1];
   assign out_clamp_stage = clp[STAGES-1];
   assign out_clamped     = |clp[STAGES-1];

`ifdef INTERVAL_CHAIN_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_items  <= '0;
         stat_clamps <= '0;
      end else if (out_valid && out_ready) begin
         if (stat_items != '1)
            stat_items <= stat_items + 32'd1;
         if (out_clamped && stat_clamps != '1)
            stat_clamps <= stat_clamps + 32'd1;
      end
   end
`endif

endmodule
